// File: rtl/brightness_fader.sv
// brightness_fader: owns the PWM brightness. Encoder pulses and host commands set a target, and
// brightness_o ramps toward it one step per tick. Breathing mode is built only with BRIGHTNESS_FADER_BREATHE_EN.
module brightness_fader #(
  parameter int unsigned CLOCK_FREQ_MHZ = 100,
  parameter int unsigned STEP_PERIOD_US = 1000,
  parameter int unsigned PWM_VALUE_SIZE = 8,
  parameter int unsigned BRIGHTNESS_INC = 5,
  parameter int unsigned RAMP_STEP      = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      inc_i,
  input  logic                      dec_i,
  input  logic                      cmd_valid_i,
  input  logic [PWM_VALUE_SIZE-1:0] cmd_target_i,
  output logic                      cmd_ready_o,
  output logic [PWM_VALUE_SIZE-1:0] brightness_o,
  output logic [PWM_VALUE_SIZE-1:0] target_o,
  output logic                      busy_o
`ifdef BRIGHTNESS_FADER_BREATHE_EN
  ,
  input  logic                      breathe_i
`endif
);

  localparam int unsigned W = PWM_VALUE_SIZE;
  localparam logic [31:0] TICK_CYCLES = 32'(CLOCK_FREQ_MHZ * STEP_PERIOD_US);
  localparam logic [31:0] TICK_LAST   = TICK_CYCLES - 32'd1;
  localparam logic [31:0] STEP_32     = 32'(RAMP_STEP);
  localparam logic [W-1:0] STEP_W     = W'(RAMP_STEP);
  localparam logic [W-1:0] INC_W      = W'(BRIGHTNESS_INC);
  localparam logic [W-1:0] MAX_VAL    = {W{1'b1}};
  localparam logic [W-1:0] INC_LIMIT  = MAX_VAL - INC_W;

`ifdef BRIGHTNESS_FADER_BREATHE_EN
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RAMP    = 2'd1,
    ST_BR_DOWN = 2'd2,
    ST_BR_UP   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1
  } state_t;
`endif

  state_t       state_reg, state_next;
  logic [W-1:0] brightness_reg, brightness_next;
  logic [W-1:0] target_reg, target_next;
  logic [31:0]  tick_cnt_reg, tick_cnt_next;
  logic         tick;
  logic         cmd_fire;

  // One step toward goal, landing exactly on it when within RAMP_STEP (no overshoot, no wrap).
  function automatic logic [W-1:0] step_toward(input logic [W-1:0] cur, input logic [W-1:0] goal);
    logic [W-1:0] diff;
    logic [W-1:0] res;
    diff = (goal > cur) ? (goal - cur) : (cur - goal);
    if (32'(diff) <= STEP_32) begin
      res = goal;
    end else if (goal > cur) begin
      res = cur + STEP_W;
    end else begin
      res = cur - STEP_W;
    end
    return res;
  endfunction

`ifdef BRIGHTNESS_FADER_BREATHE_EN
  function automatic logic [W-1:0] step_down(input logic [W-1:0] cur);
    logic [W-1:0] res;
    if (32'(cur) <= STEP_32) begin
      res = '0;
    end else begin
      res = cur - STEP_W;
    end
    return res;
  endfunction
`endif

  assign cmd_ready_o  = (state_reg == ST_IDLE);
  assign busy_o       = (state_reg != ST_IDLE);
  assign brightness_o = brightness_reg;
  assign target_o     = target_reg;
  assign cmd_fire     = cmd_valid_i && cmd_ready_o;
  assign tick         = (state_reg != ST_IDLE) && (tick_cnt_reg == TICK_LAST);

  // Host handshake has priority; encoder pulses apply in any state and saturate by being ignored.
  always_comb begin
    target_next = target_reg;
    if (cmd_fire) begin
      target_next = cmd_target_i;
    end else if (inc_i && !dec_i) begin
      if (target_reg <= INC_LIMIT) begin
        target_next = target_reg + INC_W;
      end
    end else if (dec_i && !inc_i) begin
      if (target_reg >= INC_W) begin
        target_next = target_reg - INC_W;
      end
    end
  end

  always_comb begin
    tick_cnt_next = 32'd0;
    if (state_reg != ST_IDLE && !tick) begin
      tick_cnt_next = tick_cnt_reg + 32'd1;
    end
  end

  always_comb begin
    state_next      = state_reg;
    brightness_next = brightness_reg;
    case (state_reg)
      ST_IDLE: begin
        if (brightness_reg != target_reg) begin
          state_next = ST_RAMP;
`ifdef BRIGHTNESS_FADER_BREATHE_EN
        end else if (breathe_i) begin
          state_next = ST_BR_DOWN;
`endif
        end
      end
      ST_RAMP: begin
        if (brightness_reg == target_reg) begin
          state_next = ST_IDLE;
        end else if (tick) begin
          brightness_next = step_toward(brightness_reg, target_reg);
        end
      end
`ifdef BRIGHTNESS_FADER_BREATHE_EN
      ST_BR_DOWN: begin
        if (!breathe_i) begin
          state_next = ST_RAMP;
        end else if (brightness_reg == '0) begin
          state_next = ST_BR_UP;
        end else if (tick) begin
          brightness_next = step_down(brightness_reg);
        end
      end
      ST_BR_UP: begin
        if (target_reg < brightness_reg) begin
          state_next = ST_BR_DOWN;
        end else if (brightness_reg == target_reg) begin
          state_next = breathe_i ? ST_BR_DOWN : ST_IDLE;
        end else if (tick) begin
          brightness_next = step_toward(brightness_reg, target_reg);
        end
      end
`endif
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg      <= ST_IDLE;
      brightness_reg <= '0;
      target_reg     <= '0;
      tick_cnt_reg   <= 32'd0;
    end else begin
      state_reg      <= state_next;
      brightness_reg <= brightness_next;
      target_reg     <= target_next;
      tick_cnt_reg   <= tick_cnt_next;
    end
  end

endmodule
